// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared simpleBUS definitions: default widths, slave FSM state
//               encoding and a helper for memory index width.
// Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Number of index bits needed to address a memory of the given depth.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mem_if
// Description : simpleBUS slave-port bundle. The master side drives the
//               request, the slave side returns data, ack, error and busy.
// Revision    : 1.0  initial release
// ============================================================================
interface bus_slave_mem_if #(
    parameter int DATA_W = bus_pkg::DATA_W_DEF,
    parameter int ADDR_W = bus_pkg::ADDR_W_DEF
) ();

    logic              s_sel;
    logic              s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s_dout;
    logic              s_ack;
    logic              s_err;
    logic              s_busy;

    modport master (
        output s_sel, s_wr, s_addr, s_din,
        input  s_dout, s_ack, s_err, s_busy
    );

    modport slave (
        input  s_sel, s_wr, s_addr, s_din,
        output s_dout, s_ack, s_err, s_busy
    );

endinterface
`default_nettype wire

// File: rtl/bus_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_ctrl
// Description : Request FSM for the simpleBUS memory slave: latches the
//               request, counts wait states, checks the address range and
//               produces the registered ack/err/busy strobes. It also tells
//               the memory when (and with what) to commit a transaction.
// Revision    : 1.0  initial release
// ============================================================================
module bus_slave_ctrl
    import bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 2,
    parameter int IDX_W       = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sel,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic              commit,
    output logic              commit_wr,
    output logic              commit_fault,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [DATA_W-1:0] commit_din,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);
    localparam logic            NO_WAIT = (WAIT_STATES == 0);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_wr;
    logic              lat_fault;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_din;
    logic              req_fault;

    // Full-width range check on the live address; no truncation or wrap.
    assign req_fault = ({1'b0, addr} >= LIMIT);

    // The commit edge is the edge that enters RESP. With no wait states that
    // is the accept edge itself, so the live request is used in IDLE.
    assign commit       = ((state == S_IDLE) && sel && NO_WAIT) ||
                          ((state == S_WAIT) && (cnt == 4'd1));
    assign commit_wr    = (state == S_IDLE) ? wr                   : lat_wr;
    assign commit_fault = (state == S_IDLE) ? req_fault            : lat_fault;
    assign commit_idx   = (state == S_IDLE) ? addr[IDX_W-1:0]      : lat_idx;
    assign commit_din   = (state == S_IDLE) ? din                  : lat_din;

    // Request FSM with registered ack/err/busy; ack follows the RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_fault <= 1'b0;
            lat_idx   <= '0;
            lat_din   <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ack <= (state == S_RESP);
            err <= (state == S_RESP) && lat_fault;
            case (state)
                S_IDLE: begin
                    busy <= sel;
                    if (sel) begin
                        lat_wr    <= wr;
                        lat_fault <= req_fault;
                        lat_idx   <= addr[IDX_W-1:0];
                        lat_din   <= din;
                        cnt       <= WS_LOAD;
                        state     <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    busy <= 1'b1;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_mem
// Description : simpleBUS memory slave: DEPTH x DATA_W register memory behind
//               a request/ack handshake with programmable wait states.
//               Out-of-range addresses answer with an error response.
// Revision    : 1.0  initial release
// ============================================================================
module bus_slave_mem
    import bus_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    bus_slave_mem_if.slave    bus
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout;
    logic              commit;
    logic              commit_wr;
    logic              commit_fault;
    logic [IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0] commit_din;
    logic              ack;
    logic              err;
    logic              busy;

    bus_slave_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES),
        .IDX_W       (IDX_W)
    ) u_ctrl (
        .clk          (clk),
        .reset_n      (reset_n),
        .sel          (bus.s_sel),
        .wr           (bus.s_wr),
        .addr         (bus.s_addr),
        .din          (bus.s_din),
        .commit       (commit),
        .commit_wr    (commit_wr),
        .commit_fault (commit_fault),
        .commit_idx   (commit_idx),
        .commit_din   (commit_din),
        .ack          (ack),
        .err          (err),
        .busy         (busy)
    );

    // Memory write and read-data capture on the edge entering RESP; dout
    // holds between read responses and faulting reads return zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout <= '0;
        end else if (commit) begin
            if (commit_wr && !commit_fault) begin
                mem[commit_idx] <= commit_din;
            end
            if (!commit_wr) begin
                dout <= commit_fault ? '0 : mem[commit_idx];
            end
        end
    end

    assign bus.s_dout = dout;
    assign bus.s_ack  = ack;
    assign bus.s_err  = err;
    assign bus.s_busy = busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_slave_mem
// Description : Scoreboard bench for bus_slave_mem. Two instances: one with
//               two wait states (directed + random traffic, abort by reset)
//               and one with no wait states (back-to-back held request).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bus_slave_mem;

    localparam int DEPTH = 32;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    typedef struct {
        int          acc;
        logic        err;
        logic [31:0] dout;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_slave_mem_if #(.DATA_W(32), .ADDR_W(8)) bus_a ();
    bus_slave_mem_if #(.DATA_W(32), .ADDR_W(8)) bus_b ();

    bus_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    bus_slave_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        e_a;
    exp_t        e_b;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    bit          mon_en = 1'b1;
    logic [31:0] held_a = '0;
    logic [31:0] held_b = '0;
    logic [31:0] model [DEPTH];
    logic [31:0] last_a;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Monitor A: pops on every ack; between acks checks busy, err and dout.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_a.s_ack) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_ack_queue", 32'(qa.size()), 32'd1);
                end else begin
                    e_a = qa.pop_front();
                    chk("a_ack_latency", 32'(cyc), 32'(e_a.acc + 1 + WS_A));
                    chk("a_err", 32'(bus_a.s_err), 32'(e_a.err));
                    chk("a_dout_ack", bus_a.s_dout, e_a.dout);
                    chk("a_busy_ack", 32'(bus_a.s_busy), 32'd1);
                    held_a = e_a.dout;
                end
            end else begin
                chk("a_err_no_ack", 32'(bus_a.s_err), 32'd0);
                chk("a_busy", 32'(bus_a.s_busy), 32'((qa.size() != 0) && (cyc >= qa[0].acc)));
                chk("a_dout", bus_a.s_dout,
                    ((qa.size() != 0) && (cyc >= qa[0].acc + WS_A)) ? qa[0].dout : held_a);
            end
        end
    end

    // Monitor B: same rules for the zero-wait-state instance.
    always @(negedge clk) begin
        if (bus_b.s_ack) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_ack_queue", 32'(qb.size()), 32'd1);
            end else begin
                e_b = qb.pop_front();
                chk("b_ack_latency", 32'(cyc), 32'(e_b.acc + 1 + WS_B));
                chk("b_err", 32'(bus_b.s_err), 32'(e_b.err));
                chk("b_dout_ack", bus_b.s_dout, e_b.dout);
                chk("b_busy_ack", 32'(bus_b.s_busy), 32'd1);
                held_b = e_b.dout;
            end
        end else begin
            chk("b_err_no_ack", 32'(bus_b.s_err), 32'd0);
            chk("b_busy", 32'(bus_b.s_busy), 32'((qb.size() != 0) && (cyc >= qb[0].acc)));
            chk("b_dout", bus_b.s_dout,
                ((qb.size() != 0) && (cyc >= qb[0].acc + WS_B)) ? qb[0].dout : held_b);
        end
    end

    // Issue one request on A (called just after a falling edge with A idle),
    // predict its response from the word-array model, then wait for the ack.
    // With junk set, a conflicting write is pulsed while the slave is busy.
    task automatic issue_a(input logic wr, input logic [7:0] addr, input logic [31:0] din,
                           input bit junk, input logic [7:0] jaddr, input logic [31:0] jdin);
        exp_t e;
        int   acc;
        bit   fault;
        bit   done;
        bus_a.s_sel  = 1'b1;
        bus_a.s_wr   = wr;
        bus_a.s_addr = addr;
        bus_a.s_din  = din;
        @(posedge clk); #1;
        bus_a.s_sel = 1'b0;
        acc   = cyc;
        fault = (addr >= 8'(DEPTH));
        e.acc = acc;
        e.err = fault;
        if (wr) begin
            if (!fault) model[addr[4:0]] = din;
            e.dout = last_a;
        end else begin
            e.dout = fault ? 32'd0 : model[addr[4:0]];
            last_a = e.dout;
        end
        qa.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk); #1;
            if (qa.size() == 0) begin
                done = 1'b1;
                bus_a.s_sel = 1'b0;
            end else if (junk && (cyc <= acc + WS_A)) begin
                bus_a.s_sel  = 1'b1;
                bus_a.s_wr   = 1'b1;
                bus_a.s_addr = jaddr;
                bus_a.s_din  = jdin;
            end else begin
                bus_a.s_sel = 1'b0;
            end
        end
        bus_a.s_sel = 1'b0;
        if (!done) begin
            chk("a_ack_timeout_pending", 32'(qa.size()), 32'd0);
            qa.delete();
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got no summary expected summary");
        $fatal(1);
    end

    initial begin
        int          gap;
        int          e0;
        logic [31:0] bval;
        exp_t        eb;
        bus_a.s_sel = 1'b0; bus_a.s_wr = 1'b0; bus_a.s_addr = '0; bus_a.s_din = '0;
        bus_b.s_sel = 1'b0; bus_b.s_wr = 1'b0; bus_b.s_addr = '0; bus_b.s_din = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_a  = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
        // Idle after reset: monitors check everything stays at zero.
        repeat (10) begin @(negedge clk); #1; end

        // Directed traffic on A.
        issue_a(1'b1, 8'd5,   32'hDEADBEEF, 1'b0, 8'd0, 32'd0);
        issue_a(1'b0, 8'd5,   32'd0,        1'b0, 8'd0, 32'd0);
        repeat (3) begin @(negedge clk); #1; end
        issue_a(1'b0, 8'd32,  32'd0,        1'b0, 8'd0, 32'd0);
        issue_a(1'b1, 8'd200, 32'd1,        1'b0, 8'd0, 32'd0);
        issue_a(1'b0, 8'd8,   32'd0,        1'b0, 8'd0, 32'd0);
        issue_a(1'b1, 8'd1,   32'h11,       1'b1, 8'd2, 32'h22);
        issue_a(1'b0, 8'd2,   32'd0,        1'b0, 8'd0, 32'd0);
        issue_a(1'b0, 8'd1,   32'd0,        1'b0, 8'd0, 32'd0);
        issue_a(1'b0, 8'd255, 32'd0,        1'b0, 8'd0, 32'd0);

        // Random traffic on A, including out-of-range and back-to-back.
        repeat (150) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(negedge clk); #1; end
            issue_a(1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 39)),
                    $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)), $urandom);
        end

        // Abort an in-flight write on A with reset.
        mon_en = 1'b0;
        bus_a.s_sel  = 1'b1;
        bus_a.s_wr   = 1'b1;
        bus_a.s_addr = 8'd7;
        bus_a.s_din  = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus_a.s_sel = 1'b0;
        @(negedge clk); #1;
        chk("a_busy_before_abort", 32'(bus_a.s_busy), 32'd1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("a_no_ack_after_abort", 32'(bus_a.s_ack), 32'd0);
            chk("a_idle_after_abort", 32'(bus_a.s_busy), 32'd0);
            #1;
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_a = '0;
        held_a = '0;
        mon_en = 1'b1;
        issue_a(1'b0, 8'd7, 32'd0, 1'b0, 8'd0, 32'd0);
        issue_a(1'b0, 8'd5, 32'd0, 1'b0, 8'd0, 32'd0);

        // B: write addr 3, then hold a read of addr 3 for four responses.
        bval = $urandom;
        bus_b.s_sel  = 1'b1;
        bus_b.s_wr   = 1'b1;
        bus_b.s_addr = 8'd3;
        bus_b.s_din  = bval;
        @(posedge clk); #1;
        bus_b.s_sel = 1'b0;
        eb.acc  = cyc;
        eb.err  = 1'b0;
        eb.dout = 32'd0;
        qb.push_back(eb);
        repeat (3) begin @(negedge clk); #1; end
        bus_b.s_sel = 1'b1;
        bus_b.s_wr  = 1'b0;
        @(posedge clk); #1;
        e0 = cyc;
        for (int k = 0; k < 4; k++) begin
            eb.acc  = e0 + 2 * k;
            eb.err  = 1'b0;
            eb.dout = bval;
            qb.push_back(eb);
        end
        for (int k = 0; k < 20 && cyc < e0 + 7; k++) begin
            @(negedge clk); #1;
        end
        bus_b.s_sel = 1'b0;
        repeat (4) begin @(negedge clk); #1; end
        chk("b_responses_drained", 32'(qb.size()), 32'd0);

        repeat (2) begin @(negedge clk); #1; end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
